lcd_scanner: RTL and testbench

// Downstream consumer of the display-RAM segment outputs. Steps the 2-bit LCD common (lcd_h) select

---
 rtl/lcd_scanner.sv | 127 ++++++++++++
 tb/tb_lcd_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_scanner.sv
// lcd_scanner: steps the LCD common select (lcd_h) through H=0..3, samples the
// display-RAM segment outputs once per H phase into a shadow buffer, and commits
// a complete 2x16x4 frame to registered outputs with a one-cycle valid pulse.
//
// State table
//   state     | meaning
//   ST_IDLE   | scan stopped; lcd_h=0, phase counter cleared
//   ST_SCAN   | walking H=0..3, TICK_DIV cycles per H, sample at phase SETTLE
//   ST_COMMIT | one cycle after the H=3 phase ends; frame_valid is high here
//
// Ports
//   clk          in   1   system clock
//   reset_n      in   1   asynchronous active-low reset
//   enable       in   1   1 = scan running, 0 = idle
//   lcd_blank    in   1   forces the committed frame to zero (sampled at commit only)
//   segment_a    in  16   segment A bits for the current lcd_h
//   segment_b    in  16   segment B bits for the current lcd_h
//   lcd_h        out  2   current common select, feeds display RAM
//   frame_a      out 64   committed frame, bit [h*16+i] = segment_a[i] at H=h
//   frame_b      out 64   committed frame, same layout for segment_b
//   frame_valid  out  1   one-cycle pulse when frame_a/b carry a new frame
//   frame_count  out  8   committed-frame counter, wraps 255->0
module lcd_scanner #(
    parameter int TICK_DIV = 256,
    parameter int SETTLE   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        lcd_blank,
    input  logic [15:0] segment_a,
    input  logic [15:0] segment_b,
    output logic [1:0]  lcd_h,
    output logic [63:0] frame_a,
    output logic [63:0] frame_b,
    output logic        frame_valid,
    output logic [7:0]  frame_count
);

    localparam logic [15:0] LP_LAST   = 16'(TICK_DIV - 1);
    localparam logic [15:0] LP_SETTLE = 16'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_phase;
    logic [1:0]  r_lcd_h;
    logic [63:0] r_shadow_a;
    logic [63:0] r_shadow_b;
    logic [63:0] r_frame_a;
    logic [63:0] r_frame_b;
    logic        r_frame_valid;
    logic [7:0]  r_frame_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_phase       <= '0;
            r_lcd_h       <= '0;
            r_shadow_a    <= '0;
            r_shadow_b    <= '0;
            r_frame_a     <= '0;
            r_frame_b     <= '0;
            r_frame_valid <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_phase <= '0;
                    r_lcd_h <= '0;
                    if (enable) begin
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!enable) begin
                        // Abandon the partial frame; the next frame rewrites every H slot.
                        r_state <= ST_IDLE;
                        r_phase <= '0;
                        r_lcd_h <= '0;
                    end else begin
                        if (r_phase == LP_SETTLE) begin
                            r_shadow_a[{r_lcd_h, 4'b0000} +: 16] <= segment_a;
                            r_shadow_b[{r_lcd_h, 4'b0000} +: 16] <= segment_b;
                        end
                        if (r_phase == LP_LAST) begin
                            r_phase <= '0;
                            r_lcd_h <= r_lcd_h + 2'd1;
                            if (r_lcd_h == 2'd3) begin
                                // SETTLE < TICK_DIV-1, so the H=3 sample is already in the shadow.
                                r_state       <= ST_COMMIT;
                                r_frame_a     <= lcd_blank ? '0 : r_shadow_a;
                                r_frame_b     <= lcd_blank ? '0 : r_shadow_b;
                                r_frame_valid <= 1'b1;
                                r_frame_count <= r_frame_count + 8'd1;
                            end
                        end else begin
                            r_phase <= r_phase + 16'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_phase <= '0;
                    r_lcd_h <= '0;
                    r_state <= enable ? ST_SCAN : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_phase <= '0;
                    r_lcd_h <= '0;
                end
            endcase
        end
    end

    assign lcd_h       = r_lcd_h;
    assign frame_a     = r_frame_a;
    assign frame_b     = r_frame_b;
    assign frame_valid = r_frame_valid;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_lcd_scanner.sv
// Testbench for lcd_scanner with TICK_DIV=8, SETTLE=2. Segment inputs come from a
// display-RAM model keyed on lcd_h; committed frames are checked by a scoreboard.
module tb_lcd_scanner;

    localparam int TD = 8;
    localparam int FP = 4 * TD + 1;
    localparam logic [15:0] A_TAB [4] = '{16'h1E2D, 16'hC3B4, 16'h5A69, 16'h8778};

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        lcd_blank;
    logic [15:0] segment_a;
    logic [15:0] segment_b;
    logic [1:0]  lcd_h;
    logic [63:0] frame_a;
    logic [63:0] frame_b;
    logic        frame_valid;
    logic [7:0]  frame_count;

    logic [15:0] key;
    logic        glitch;

    typedef struct {
        int          cyc;
        logic [63:0] a;
        logic [63:0] b;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp;
    int          n_err;
    int          cyc;
    int          e0;
    logic [7:0]  exp_count;
    logic [63:0] last_a;
    logic [63:0] last_b;

    lcd_scanner #(.TICK_DIV(TD), .SETTLE(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .lcd_blank  (lcd_blank),
        .segment_a  (segment_a),
        .segment_b  (segment_b),
        .lcd_h      (lcd_h),
        .frame_a    (frame_a),
        .frame_b    (frame_b),
        .frame_valid(frame_valid),
        .frame_count(frame_count)
    );

    // Display RAM model: combinational on lcd_h, with an optional forced-high glitch on A.
    assign segment_a = glitch ? 16'hFFFF : (A_TAB[lcd_h] ^ key);
    assign segment_b = ~(A_TAB[lcd_h] ^ key);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] frame_of(input logic [15:0] kv);
        return {A_TAB[3] ^ kv, A_TAB[2] ^ kv, A_TAB[1] ^ kv, A_TAB[0] ^ kv};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every frame_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset_n && frame_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                check("frame_a", frame_a, e.a);
                check("frame_b", frame_b, e.b);
                check("frame_count", 64'(frame_count), 64'(e.cnt));
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("missing_pulse", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    // Runs n back-to-back frames from IDLE. bmode: 0 blank off, 1 blank on all frame,
    // 2 blank on except across the commit edge. gl forces segment_a high in phases 3..7.
    task automatic run_frames(input int n, input logic [15:0] kv, input bit gl, input int bmode);
        int k33;
        exp_t e;
        key       = kv;
        glitch    = 1'b0;
        lcd_blank = (bmode != 0);
        @(posedge clk); #1;
        enable = 1'b1;
        e0 = cyc + 1;
        for (int j = 0; j < n; j++) begin
            e.cyc     = e0 + 32 + FP * j;
            e.a       = (bmode == 1) ? 64'd0 : frame_of(kv);
            e.b       = (bmode == 1) ? 64'd0 : ~frame_of(kv);
            e.cnt     = exp_count + 8'd1;
            exp_count = e.cnt;
            last_a    = e.a;
            last_b    = e.b;
            sb.push_back(e);
        end
        for (int k = 0; k < FP * n; k++) begin
            @(posedge clk); #1;
            k33       = k % FP;
            glitch    = gl && (k33 < 32) && ((k33 % TD) >= 3);
            lcd_blank = (bmode == 1) || (bmode == 2 && k33 != 31);
            check("lcd_h_seq", 64'(lcd_h), (k33 < 32) ? 64'(k33 / TD) : 64'd0);
        end
        enable    = 1'b0;
        glitch    = 1'b0;
        lcd_blank = 1'b0;
        drain();
        @(posedge clk); #1;
        check("lcd_h_idle", 64'(lcd_h), 64'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; e0 = 0;
        exp_count = '0; last_a = '0; last_b = '0;
        enable = 1'b0; lcd_blank = 1'b0; key = '0; glitch = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("rst_lcd_h", 64'(lcd_h), 64'd0);
        check("rst_frame_a", frame_a, 64'd0);
        check("rst_frame_b", frame_b, 64'd0);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_count", 64'(frame_count), 64'd0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // Two back-to-back frames, pulses at E32 and E65.
        run_frames(2, 16'h0000, 1'b0, 0);
        // Glitches outside the sample phase must not reach the frame.
        run_frames(1, 16'h3C5A, 1'b1, 0);
        // Blanking at the commit edge, then recovery, then blank that misses the commit edge.
        run_frames(1, 16'h0F0F, 1'b0, 1);
        run_frames(1, 16'h0F0F, 1'b0, 0);
        run_frames(1, 16'h6E21, 1'b0, 2);

        // Drop enable during H=2: back to IDLE, outputs hold, no pulse.
        key = 16'h1111;
        @(posedge clk); #1;
        enable = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            check("lcd_h_partial", 64'(lcd_h), 64'(k / TD));
        end
        enable = 1'b0;
        @(posedge clk); #1;
        check("abort_lcd_h", 64'(lcd_h), 64'd0);
        check("abort_frame_a", frame_a, last_a);
        check("abort_frame_b", frame_b, last_b);
        check("abort_count", 64'(frame_count), 64'(exp_count));
        repeat (40) @(posedge clk);
        #1 check("abort_idle_lcd_h", 64'(lcd_h), 64'd0);
        run_frames(1, 16'hA0A0, 1'b0, 0);

        // 256 frames: frame_count wraps through 255->0.
        run_frames(256, 16'h5555, 1'b0, 0);
        check("wrap_count", 64'(frame_count), 64'(exp_count));

        // Asynchronous reset mid-SCAN, no pending commit survives.
        key = 16'h2468;
        @(posedge clk); #1;
        enable = 1'b1;
        repeat (12) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("midrst_lcd_h", 64'(lcd_h), 64'd0);
        check("midrst_frame_a", frame_a, 64'd0);
        check("midrst_frame_b", frame_b, 64'd0);
        check("midrst_valid", 64'(frame_valid), 64'd0);
        check("midrst_count", 64'(frame_count), 64'd0);
        enable    = 1'b0;
        exp_count = '0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 check("postrst_lcd_h", 64'(lcd_h), 64'd0);
        run_frames(1, 16'h0001, 1'b0, 0);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
